// File: rtl/demux_tdm.sv
// TDM receive demultiplexer: serial slot stream back to N parallel channels.
// Frames align on frame_sync; dout updates only on a complete frame.
module demux_tdm #(
  parameter int SEL_W = 3
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    din,
  input  logic                    din_valid,
  input  logic                    frame_sync,
  output logic [(2**SEL_W)-1:0]   dout,
  output logic                    frame_valid,
  output logic [SEL_W-1:0]        slot,
  output logic                    locked,
  output logic                    sync_err
);

  localparam int N = 2**SEL_W;

  typedef enum logic [0:0] {
    HUNT,
    LOCKED
  } state_t;

  state_t           state;
  logic [N-2:0]     ch;
  logic [N-2:0]     ch_wr;
  logic [N-2:0]     ch_first;
  logic             slot_zero;
  logic             slot_last;
  logic             early;
  logic             missing;
  logic             last;

  assign slot_zero = (slot == '0);
  assign slot_last = (slot == SEL_W'(N - 1));
  assign early     = frame_sync & ~slot_zero;
  assign missing   = ~frame_sync & slot_zero;
  assign last      = ~frame_sync & slot_last;

  always_comb begin
    ch_wr = ch;
    for (int i = 0; i < N - 1; i++) begin
      if (slot == SEL_W'(i)) ch_wr[i] = din;
    end
  end

  // Start of a fresh frame: everything but slot 0 cleared.
  always_comb begin
    ch_first    = '0;
    ch_first[0] = din;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= HUNT;
      slot        <= '0;
      ch          <= '0;
      dout        <= '0;
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      locked      <= 1'b0;
    end else begin
      frame_valid <= 1'b0;
      sync_err    <= 1'b0;
      if (din_valid) begin
        unique case (state)
          HUNT: begin
            if (frame_sync) begin
              ch     <= ch_first;
              slot   <= SEL_W'(1);
              state  <= LOCKED;
              locked <= 1'b1;
            end
          end
          LOCKED: begin
            unique case (1'b1)
              early: begin
                sync_err <= 1'b1;
                ch       <= ch_first;
                slot     <= SEL_W'(1);
              end
              missing: begin
                sync_err <= 1'b1;
                state    <= HUNT;
                locked   <= 1'b0;
              end
              last: begin
                dout        <= {din, ch};
                frame_valid <= 1'b1;
                slot        <= slot + SEL_W'(1);
              end
              default: begin
                ch   <= ch_wr;
                slot <= slot + SEL_W'(1);
              end
            endcase
          end
          default: state <= HUNT;
        endcase
      end
    end
  end

endmodule

// File: doc/demux_tdm.md
# demux_tdm

Time-division demultiplexer: the receive-side counterpart of the team's N:1 multiplexer blocks. A serial bit stream, one channel bit per valid cycle and slot 0 marked by `frame_sync`, is distributed back into N parallel channel bits. Each complete frame is presented on a registered parallel output with a one-cycle strobe. It sits after a mux-based serializer and restores the per-channel signals that the mux selected in turn.

## Interface
- `SEL_W`, default 3: slot-index width. Channel count N = 2**SEL_W (1 → 2:1, 2 → 4:1, 3 → 8:1).

Ports:
- `clk` input, 1 bit: single clock; all state updates on the rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `din` input, 1 bit: serial channel bit for the current slot.
- `din_valid` input, 1 bit: qualifies `din` and `frame_sync`. Cycles with this low are ignored.
- `frame_sync` input, 1 bit: marks the current valid bit as slot 0. Meaningful only when `din_valid` = 1.
- `dout` output, N bits: last complete frame; `dout[i]` = channel i.
- `frame_valid` output, 1 bit: one-cycle pulse when `dout` is updated.
- `slot` output, SEL_W bits: index the next valid bit will be written to.
- `locked` output, 1 bit: high in the LOCKED state.
- `sync_err` output, 1 bit: one-cycle pulse on a framing error.

## Operation
- The block holds an internal partial-frame register `ch[N-2:0]`, a slot counter, and a 2-state FSM with states HUNT and LOCKED.
- Reset values: state = HUNT, `slot` = 0, `ch` = 0, `dout` = 0, `frame_valid` = 0, `sync_err` = 0, `locked` = 0.

HUNT:
- `din_valid & frame_sync`:
  - `ch[0]` ← `din`, `slot` ← 1, state → LOCKED.
- `din_valid & !frame_sync`: the bit is discarded; no state change.

LOCKED, on `din_valid`:
- `frame_sync` with `slot` = 0: normal write to slot 0.
- `frame_sync` with `slot` ≠ 0 (early sync):
  - `sync_err` pulses.
  - The partial frame is discarded: `ch` is cleared, then `ch[0]` ← `din`, `slot` ← 1.
  - State stays LOCKED and `frame_valid` does not pulse.
- `!frame_sync` with `slot` = 0 (missing sync):
  - `sync_err` pulses.
  - The bit is discarded, state → HUNT, `slot` stays 0.
- Normal write, 0 ≤ `slot` < N-1: `ch[slot]` ← `din`, `slot` ← `slot` + 1.
- Normal write at `slot` = N-1:
  - `dout` ← {`din`, `ch[N-2:0]`}, `frame_valid` pulses.
  - `slot` wraps to 0 (modulo-N arithmetic in SEL_W bits).

General rules:
- `din_valid` = 0: `slot`, `ch`, state and `dout` hold; both pulse outputs are 0.
- `dout` holds its value until the next complete frame. It is never partially updated.
- `frame_valid` and `sync_err` are never high in the same cycle. They are not both possible on one input.

## Timing
- All outputs are registered. The effect of the valid input sampled at edge k is visible after edge k.
- Latency: `frame_valid` and the new `dout` appear the cycle after the last bit (slot N-1) is sampled.
- Minimum frame length is N consecutive valid cycles. The throughput is one frame per N cycles with back-to-back frames and no gap between them.
- Idle cycles (`din_valid` = 0) may appear anywhere inside a frame without affecting it.
- `sync_err` appears one cycle after the offending bit is sampled.
- Re-lock from HUNT: the sync bit is accepted on the same edge it is sampled, so the next full frame is delivered N cycles later.
- Reset mid-frame: on the edge where `reset` = 1, every register returns to its reset value, including `dout`. Reset has priority over all inputs sampled on that edge.

## Test plan
- **Basic frame:** with N = 8, send `frame_sync` on the first bit and bits 1,0,1,0,0,1,0,1 (ch0…ch7) back to back.
  - Expect `dout` = 8'hA5 with `frame_valid` high for exactly 1 cycle, one cycle after the 8th bit; `slot` = 0 and `locked` = 1 afterwards.
- **Gaps and back-to-back:** send frame 8'h3C with `din_valid` low for 2 cycles after slot 3, then immediately frame 8'hC3.
  - Expect `dout` = 8'h3C then 8'hC3, with two `frame_valid` pulses.
- **Hunt discard:** after reset, send 5 valid bits without `frame_sync`, then a synced 8'hFF frame.
  - Expect no pulses until `dout` = 8'hFF; `locked` rises the cycle after the sync bit.
- **Early sync:** send `frame_sync` at `slot` = 5, followed by a full frame 8'h81.
  - Expect a `sync_err` pulse and no `frame_valid` for the aborted frame, then `dout` = 8'h81.
- **Missing sync:** after frame 8'h0F, send a valid bit at `slot` = 0 with `frame_sync` = 0.
  - Expect `sync_err` pulse, `locked` → 0, `dout` holds 8'h0F.
- **Reset mid-frame:** assert `reset` at `slot` = 4 after a prior frame 8'h5A.
  - Expect `dout` = 0, `slot` = 0, `locked` = 0 the next cycle, and no `frame_valid`.
  - Also repeat the basic frame with `SEL_W` = 1 (bits 0,1 → `dout` = 2'b10) and `SEL_W` = 2.
